// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// ------------------------------------------------------------------------
// Receives 8N1 frames from an asynchronous UART line by counting clk_in
// ticks per bit. Recovered bytes go into a first-word-fall-through FIFO and
// are handed downstream over a valid/ready handshake. Stop-bit failures and
// bytes lost to a full FIFO are reported as one-cycle pulses.
//
// Ports
//   clk_in       in   single clock, rising edge
//   reset        in   synchronous, active-high
//   rx_in        in   asynchronous UART line, idle high
//   rx_data      out  [7:0] byte at FIFO head (meaningful while rx_valid)
//   rx_valid     out  FIFO non-empty
//   rx_ready     in   consumer accepts the head byte
//   rx_running   out  receiver FSM is not idle
//   frame_error  out  one-cycle pulse: stop bit sampled low
//   overflow     out  one-cycle pulse: good byte dropped, FIFO full
//   o_dbg_state  out  [2:0] current receiver FSM state (debug visibility)
//
// Handshake: a byte transfers on every rising edge where rx_valid and
// rx_ready are both high. rx_valid never depends on rx_ready, rx_data is
// stable while rx_valid is high and no transfer has happened, and
// rx_ready may be held high with no data present (nothing is popped).
// ------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int TICKS_PER_BIT    = 191,
  parameter int FIFO_DEPTH_BASE2 = 2
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_running,
  output logic       frame_error,
  output logic       overflow,
  output logic [2:0] o_dbg_state
);

  localparam int CW    = $clog2(TICKS_PER_BIT);
  localparam int AW    = FIFO_DEPTH_BASE2;
  localparam int DEPTH = 1 << AW;

  // Half-bit point in START lands the later samples near mid-bit.
  localparam logic [CW-1:0] CNT_HALF = CW'(TICKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(TICKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_START      = 3'd1,
    S_DATA       = 3'd2,
    S_STOP       = 3'd3,
    S_BREAK_WAIT = 3'd4
  } state_t;

  // Synchronizer
  logic r_sync1;
  logic r_sync2;

  // Receiver
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_frame_error;
  logic          r_overflow;

  // FIFO
  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;

  state_t        w_next_state;
  logic [CW-1:0] w_next_cnt;
  logic [2:0]    w_next_bit_idx;
  logic [7:0]    w_next_shift;
  logic          w_stop_good;
  logic          w_stop_bad;
  logic          w_rx_s;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  // ----------------------------------------------------------------------
  // Two-flop synchronizer; both flops reset to the idle (high) level.
  // ----------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  // ----------------------------------------------------------------------
  // Receiver FSM: state register
  // ----------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_next_state;
      r_cnt     <= w_next_cnt;
      r_bit_idx <= w_next_bit_idx;
      r_shift   <= w_next_shift;
    end
  end

  // ----------------------------------------------------------------------
  // Receiver FSM: next state and datapath
  // ----------------------------------------------------------------------
  always_comb begin
    w_next_state   = r_state;
    w_next_cnt     = r_cnt + CW'(1);
    w_next_bit_idx = r_bit_idx;
    w_next_shift   = r_shift;
    w_stop_good    = 1'b0;
    w_stop_bad     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_next_cnt = '0;
        if (!w_rx_s) begin
          w_next_state = S_START;
        end
      end

      S_START: begin
        if (r_cnt == CNT_HALF) begin
          w_next_cnt = '0;
          if (w_rx_s) begin
            // Line already back high at mid start bit: a glitch.
            w_next_state = S_IDLE;
          end else begin
            w_next_state   = S_DATA;
            w_next_bit_idx = '0;
          end
        end
      end

      S_DATA: begin
        if (r_cnt == CNT_FULL) begin
          w_next_cnt     = '0;
          w_next_shift   = {w_rx_s, r_shift[7:1]};  // LSB arrives first
          w_next_bit_idx = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
            w_next_state = S_STOP;
          end
        end
      end

      S_STOP: begin
        if (r_cnt == CNT_FULL) begin
          w_next_cnt = '0;
          if (w_rx_s) begin
            w_stop_good  = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_stop_bad   = 1'b1;
            w_next_state = S_BREAK_WAIT;
          end
        end
      end

      S_BREAK_WAIT: begin
        // Line held low past the stop bit (break or misframe): wait it out
        // so the low level is not taken as a new start bit.
        w_next_cnt = '0;
        if (w_rx_s) begin
          w_next_state = S_IDLE;
        end
      end

      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  // ----------------------------------------------------------------------
  // FIFO: pointers carry one extra wrap bit to tell full from empty.
  // ----------------------------------------------------------------------
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = !w_empty && rx_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign w_push  = w_stop_good && (!w_full || w_pop);
  assign w_drop  = w_stop_good && w_full && !w_pop;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr[AW-1:0]] <= w_next_shift;
        r_wptr                <= r_wptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (AW+1)'(1);
      end
    end
  end

  // ----------------------------------------------------------------------
  // Status pulses, visible the cycle after the stop-bit sample.
  // ----------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_frame_error <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_frame_error <= w_stop_bad;
      r_overflow    <= w_drop;
    end
  end

  assign rx_data     = r_mem[r_rptr[AW-1:0]];
  assign rx_valid    = !w_empty;
  assign rx_running  = (r_state != S_IDLE);
  assign frame_error = r_frame_error;
  assign overflow    = r_overflow;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo at TICKS_PER_BIT=16, FIFO depth 4.
// Frames are driven onto rx_in bit by bit; each frame's outcome (push, drop
// on full, frame error) is predicted from queue occupancy at the stop-bit
// sample edge and kept in exp_q. A monitor compares every handshake and
// every status pulse against that prediction.
module tb_uart_rx_fifo;

  localparam int TPB   = 16;
  localparam int DEPTH = 4;
  // Pin edge -> 2 sync cycles -> 1 cycle into START -> half bit to the
  // start-bit check -> 8 data bits -> stop bit sample.
  localparam int SAMPLE_LAT = 3 + TPB / 2 + 9 * TPB;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       rx_in;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_running;
  logic       frame_error;
  logic       overflow;
  logic [2:0] dbg_state;

  uart_rx_fifo #(
    .TICKS_PER_BIT   (TPB),
    .FIFO_DEPTH_BASE2(2)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .rx_in      (rx_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_running (rx_running),
    .frame_error(frame_error),
    .overflow   (overflow),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete in time (cycle %0d)", cyc);
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    int         t;
    logic [7:0] d;
    bit         good;
  } frame_t;

  frame_t     pend_q[$];
  logic [7:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int ev_cyc = -1;
  bit ev_fe  = 1'b0;
  bit ev_ovf = 1'b0;
  int ovf_seen = 0;
  int fe_seen  = 0;
  int spurious = 0;
  bit rnd_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk_in) begin
    frame_t     f;
    logic [7:0] e;
    if (reset) begin
      exp_q.delete();
      pend_q.delete();
      ev_cyc = -1;
    end else begin
      if (overflow)    ovf_seen++;
      if (frame_error) fe_seen++;
      if (cyc == ev_cyc) begin
        check("frame_error_pulse", frame_error, ev_fe);
        check("overflow_pulse", overflow, ev_ovf);
      end else if (frame_error || overflow) begin
        spurious++;
      end
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL pop_unexpected: got 0x%0h expected no data (cycle %0d)", rx_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("pop_data", rx_data, e);
        end
      end
      // Upcoming edge is a stop-bit sample: decide the frame's fate using
      // occupancy after any pop happening on that same edge.
      if (pend_q.size() > 0 && pend_q[0].t == cyc + 1) begin
        f = pend_q.pop_front();
        ev_cyc = cyc + 1;
        ev_fe  = !f.good;
        ev_ovf = 1'b0;
        if (f.good) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(f.d);
          else                      ev_ovf = 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Caller must be at posedge+1. Returns at posedge+1 with the line high.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int stop_bits);
    frame_t f;
    rx_in  = 1'b0;
    f.t    = cyc + SAMPLE_LAT;
    f.d    = d;
    f.good = stop_ok;
    pend_q.push_back(f);
    for (int i = 0; i < 8; i++) begin
      tick(TPB);
      rx_in = d[i];
    end
    tick(TPB);
    rx_in = stop_ok;
    tick(TPB * stop_bits);
    rx_in = 1'b1;
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    for (int i = 0; i < 50 && rx_valid; i++) tick(1);
    rx_ready = 1'b0;
    tick(1);
    check("drain_valid", rx_valid, 1'b0);
    check("drain_model_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_valid"}, rx_valid, 1'b0);
    check({tag, "_rx_running"}, rx_running, 1'b0);
    check({tag, "_frame_error"}, frame_error, 1'b0);
    check({tag, "_overflow"}, overflow, 1'b0);
    check({tag, "_rx_data"}, rx_data, 8'h00);
    check({tag, "_state_idle"}, dbg_state, 3'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ovf0;
    int fe0;
    reset    = 1'b1;
    rx_in    = 1'b1;
    rx_ready = 1'b0;
    tick(3);
    check_reset_values("reset");
    reset = 1'b0;
    tick(5);

    // Single byte, consumer stalled: valid appears one cycle after sample.
    fork
      send_frame(8'h4C, 1'b1, 1);
      begin
        tick(SAMPLE_LAT - 1);
        check("t1_valid_before", rx_valid, 1'b0);
        tick(1);
        check("t1_valid_after", rx_valid, 1'b1);
        check("t1_data", rx_data, 8'h4C);
      end
    join
    tick(4);
    drain();

    // Back-to-back 0x00, 0xFF then sustained pops.
    send_frame(8'h00, 1'b1, 1);
    send_frame(8'hFF, 1'b1, 1);
    tick(2);
    rx_ready = 1'b1;
    check("t2_head0", rx_data, 8'h00);
    tick(1);
    check("t2_valid1", rx_valid, 1'b1);
    check("t2_head1", rx_data, 8'hFF);
    tick(1);
    check("t2_empty", rx_valid, 1'b0);
    rx_ready = 1'b0;
    tick(2);

    // Five bytes into a depth-4 FIFO: exactly one overflow.
    ovf0 = ovf_seen;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1);
    tick(3);
    check("t3_overflow_count", ovf_seen - ovf0, 1);
    drain();

    // Full FIFO with a pop on the 5th byte's sample edge: no overflow.
    ovf0 = ovf_seen;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1);
    fork
      send_frame(8'h05, 1'b1, 1);
      begin
        tick(SAMPLE_LAT - 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end
    join
    tick(3);
    check("t4_overflow_count", ovf_seen - ovf0, 0);
    drain();

    // Stop bit held low for 20 bit times, then a good frame.
    fe0 = fe_seen;
    fork
      send_frame(8'h55, 1'b0, 20);
      begin
        tick(SAMPLE_LAT + 10 * TPB);
        check("t5_running_in_break", rx_running, 1'b1);
        check("t5_fifo_unchanged", rx_valid, 1'b0);
      end
    join
    tick(4);
    check("t5_running_released", rx_running, 1'b0);
    check("t5_fe_count", fe_seen - fe0, 1);
    send_frame(8'hA5, 1'b1, 1);
    tick(2);
    check("t5_a5_valid", rx_valid, 1'b1);
    drain();

    // Four-cycle low glitch on an idle line.
    rx_in = 1'b0;
    tick(4);
    rx_in = 1'b1;
    check("t6_glitch_running", rx_running, 1'b1);
    tick(8);
    check("t6_glitch_idle", rx_running, 1'b0);
    tick(TPB * 10);
    check("t6_no_push", rx_valid, 1'b0);

    // Reset in the middle of a frame's data bits.
    send_frame(8'h3C, 1'b1, 1);
    tick(2);
    check("t7_pre_reset_data", rx_data, 8'h3C);
    fork
      send_frame(8'hFF, 1'b1, 1);
      begin
        tick(60);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_reset_values("t7");
      end
    join
    tick(3 * TPB);
    check("t7_quiet_after", rx_valid, 1'b0);

    // Randomized traffic with random consumer stalls.
    fork
      begin
        for (int n = 0; n < 30; n++) begin
          logic [7:0] d;
          d = 8'($urandom_range(0, 255));
          if ($urandom_range(0, 7) == 0) begin
            send_frame(d, 1'b0, 1);
            tick(2 * TPB);
          end else begin
            send_frame(d, 1'b1, 1);
            tick($urandom_range(0, TPB));
          end
        end
        tick(4);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          rx_ready = ($urandom_range(0, 9) < 3);
          tick($urandom_range(1, 400));
        end
        rx_ready = 1'b0;
      end
    join
    drain();

    check("final_no_spurious_pulses", spurious, 0);
    check("final_pending_empty", pend_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
